// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the parametrised counter and its bench.
// Functions work on a maximum-width vector; callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 16;

    typedef logic [GRAY_MAX_WIDTH-1:0] gvec_t;

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits decode to zero, so a narrower code decodes unchanged.
    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b = '0;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_param.sv
// Up/down binary counter with registered Gray image and wrap pulse.
// Binary and Gray loads; Gray output comes straight from a flop.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY =
        WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_BIN)));

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;
    logic [WIDTH-1:0] load_bin;

    always_comb begin
        load_bin  = load_val;
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (load_gray) begin
            load_bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(load_val)));
        end
        if (load) begin
            bin_next = load_bin;
        end else if (en && up) begin
            bin_next  = bin_q + 1'b1;
            wrap_next = &bin_q;
        end else if (en) begin
            bin_next  = bin_q - 1'b1;
            wrap_next = ~|bin_q;
        end
        // Gray image is built from the next binary value so both flops agree.
        gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            wrap_q <= wrap_next;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param at widths 4, 2 and 16.
// Directed steps followed by a random sweep checked by a scoreboard.
module tb_gray_counter_param;
    import gray_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic        load_gray;
    logic [15:0] load_val;

    logic [3:0]  bin4, gray4;
    logic [1:0]  bin2, gray2;
    logic [15:0] bin16, gray16;
    logic        wrap4, wrap2, wrap16;

    int checks;
    int failures;

    typedef struct {
        int          k;
        logic [15:0] b;
        logic [15:0] g;
        logic        w;
    } exp_t;

    exp_t        sb[$];
    int          wd[3];
    logic [15:0] rv[3];
    logic [15:0] m_bin[3];

    gray_counter_param #(.WIDTH(4), .RST_VAL(5)) u4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val[3:0]),
        .bin_out(bin4), .gray_out(gray4), .wrap(wrap4)
    );

    gray_counter_param #(.WIDTH(2), .RST_VAL(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val[1:0]),
        .bin_out(bin2), .gray_out(gray2), .wrap(wrap2)
    );

    gray_counter_param #(.WIDTH(16), .RST_VAL(16'hABCD)) u16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_out(bin16), .gray_out(gray16), .wrap(wrap16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_bin[k] = rv[k];
    endtask

    task automatic step();
        exp_t        e;
        logic [16:0] one;
        logic [15:0] mask, b, nb, lv;
        logic        nw;
        one = 17'd1;
        for (int k = 0; k < 3; k++) begin
            mask = 16'((one << wd[k]) - 17'd1);
            b    = m_bin[k];
            lv   = load_val & mask;
            nw   = 1'b0;
            if (load) nb = load_gray ? gray2bin(lv) : lv;
            else if (en && up) begin
                nb = (b + 16'd1) & mask;
                nw = (b == mask);
            end else if (en) begin
                nb = (b - 16'd1) & mask;
                nw = (b == 16'd0);
            end else nb = b;
            m_bin[k] = nb;
            e.k = k; e.b = nb; e.g = bin2gray(nb); e.w = nw;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.k)
                0: begin
                    chk("w4_bin",  16'(bin4),  e.b);
                    chk("w4_gray", 16'(gray4), e.g);
                    chk("w4_wrap", 16'(wrap4), 16'(e.w));
                end
                1: begin
                    chk("w2_bin",  16'(bin2),  e.b);
                    chk("w2_gray", 16'(gray2), e.g);
                    chk("w2_wrap", 16'(wrap2), 16'(e.w));
                end
                default: begin
                    chk("w16_bin",  bin16,  e.b);
                    chk("w16_gray", gray16, e.g);
                    chk("w16_wrap", 16'(wrap16), 16'(e.w));
                end
            endcase
        end
    endtask

    initial begin
        logic [3:0] prev;
        checks = 0; failures = 0;
        wd = '{4, 2, 16};
        rv = '{16'd5, 16'd2, 16'hABCD};
        model_reset();
        rst = 1'b0; en = 1'b0; up = 1'b0;
        load = 1'b0; load_gray = 1'b0; load_val = '0;

        #12;
        chk("rst_bin4",   16'(bin4),  16'd5);
        chk("rst_gray4",  16'(gray4), 16'b0111);
        chk("rst_wrap4",  16'(wrap4), 16'd0);
        chk("rst_bin2",   16'(bin2),  16'd2);
        chk("rst_gray2",  16'(gray2), 16'd3);
        chk("rst_bin16",  bin16,      16'hABCD);
        chk("rst_gray16", gray16,     16'hFE2B);
        @(posedge clk);
        #1 rst = 1'b1;

        repeat (3) begin
            step();
            chk("hold_bin4",  16'(bin4),  16'd5);
            chk("hold_gray4", 16'(gray4), 16'b0111);
            chk("hold_wrap4", 16'(wrap4), 16'd0);
        end

        load = 1'b1; load_val = 16'd0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            prev = gray4;
            step();
            chk("up_bin4",  16'(bin4),  16'(i % 16));
            chk("up_wrap4", 16'(wrap4), 16'(i == 16));
            chk("up_onebit", 16'($countones(prev ^ gray4)), 16'd1);
        end

        up = 1'b0;
        step();
        chk("dn0_bin4", 16'(bin4), 16'd0);
        chk("dn0_gray4", 16'(gray4), 16'b0000);
        chk("dn0_wrap4", 16'(wrap4), 16'd0);
        step();
        chk("dn1_bin4", 16'(bin4), 16'd15);
        chk("dn1_gray4", 16'(gray4), 16'b1000);
        chk("dn1_wrap4", 16'(wrap4), 16'd1);
        step();
        chk("dn2_bin4", 16'(bin4), 16'd14);
        chk("dn2_gray4", 16'(gray4), 16'b1001);
        chk("dn2_wrap4", 16'(wrap4), 16'd0);
        en = 1'b0;

        load = 1'b1; load_gray = 1'b0; load_val = 16'd9;
        step();
        chk("ldb_bin4",  16'(bin4),  16'd9);
        chk("ldb_gray4", 16'(gray4), 16'b1101);
        load_gray = 1'b1; load_val = 16'b1101;
        step();
        chk("ldg_bin4", 16'(bin4), 16'd9);
        load_gray = 1'b0; load_val = 16'd15;
        step();
        en = 1'b1; up = 1'b1; load_val = 16'd3;
        step();
        chk("ldov_bin4",  16'(bin4),  16'd3);
        chk("ldov_wrap4", 16'(wrap4), 16'd0);

        en = 1'b0; load_val = 16'd6;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("mid_bin4", 16'(bin4), 16'd7);
        #3 rst = 1'b0;
        model_reset();
        #1;
        chk("arst_bin4",  16'(bin4),  16'd5);
        chk("arst_gray4", 16'(gray4), 16'b0111);
        chk("arst_wrap4", 16'(wrap4), 16'd0);
        chk("arst_bin16", bin16,      16'hABCD);
        #1 rst = 1'b1;
        step();
        chk("resume_bin4", 16'(bin4), 16'd6);

        repeat (10000) begin
            load      = ($urandom_range(0, 7) == 0);
            en        = ($urandom_range(0, 3) != 0);
            up        = 1'($urandom);
            load_gray = 1'($urandom);
            load_val  = 16'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
